// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between IFU and LSU.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   grant_lsu;
    logic   grant_ifu;
    logic   accept;

`ifdef MEM_ARB_RR_EN
    logic last;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || !last);
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
    end
`endif

    assign grant_ifu = ifu_req_valid && !grant_lsu;
    assign accept    = (state == IDLE) && (grant_lsu || grant_ifu);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_lsu || grant_ifu) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    ifu_resp_valid = !owner;
                    lsu_resp_valid = owner;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stores carry no read data back to the LSU
    assign ifu_rdata = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata = (lsu_resp_valid && !mem_wen) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= grant_lsu;
                if (grant_lsu) begin
                    mem_wen   <= lsu_wen;
                    mem_addr  <= lsu_addr;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wen ? lsu_wmask : '0;
                end else begin
                    mem_wen   <= 1'b0;
                    mem_addr  <= ifu_addr;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b0;
        end else if (accept) begin
            last <= grant_lsu;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard testbench for mem_arbiter.
// Expected responses are queued at grant time and checked on response.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic        lsu;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    bit   grants[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0413;
        return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    // Memory model: answers one cycle after a request handshake
    bit          auto_mem = 1'b1;
    bit          hs_q     = 1'b0;
    logic [63:0] addr_q;

    always @(negedge clk) begin
        hs_q   = mem_req_valid && mem_req_ready && !rst;
        addr_q = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        if (auto_mem) begin
            mem_resp_valid = hs_q;
            mem_rdata      = hs_q ? data_of(addr_q) : 64'h0;
        end
    end

    // Monitor: grant bookkeeping, request fields, response scoreboard
    bit          chk_mem = 1'b0;
    bit          exp_lsu;
    logic        exp_wen;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wmask;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk_mem = 1'b0;
        end else begin
            if (chk_mem) begin
                check("req_valid", 64'(mem_req_valid), 64'd1);
                check("req_wen", 64'(mem_wen), 64'(exp_wen));
                check("req_addr", mem_addr, exp_addr);
                check("req_wmask", 64'(mem_wmask), 64'(exp_wmask));
                if (exp_lsu) check("req_wdata", mem_wdata, exp_wdata);
                chk_mem = 1'b0;
            end
            if (ifu_req_ready || lsu_req_ready) begin
                check("one_ready", 64'(ifu_req_ready && lsu_req_ready), 64'd0);
                exp_lsu = lsu_req_ready;
                if (lsu_req_ready) begin
                    exp_wen   = lsu_wen;
                    exp_addr  = lsu_addr;
                    exp_wdata = lsu_wdata;
                    exp_wmask = lsu_wen ? lsu_wmask : 8'h00;
                    sb.push_back('{1'b1, lsu_wen ? 64'h0 : data_of(lsu_addr)});
                end else begin
                    exp_wen   = 1'b0;
                    exp_addr  = ifu_addr;
                    exp_wdata = 64'h0;
                    exp_wmask = 8'h00;
                    sb.push_back('{1'b0, data_of(ifu_addr)});
                end
                grants.push_back(exp_lsu);
                chk_mem = 1'b1;
            end
            if (ifu_resp_valid || lsu_resp_valid) begin
                check("resp_onehot", 64'(ifu_resp_valid && lsu_resp_valid), 64'd0);
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_owner", 64'(lsu_resp_valid), 64'(e.lsu));
                    check("resp_data", lsu_resp_valid ? lsu_rdata : ifu_rdata,
                          e.data);
                end
            end
            if (!ifu_resp_valid) check("ifu_rdata_zero", ifu_rdata, 64'h0);
            if (!lsu_resp_valid) check("lsu_rdata_zero", lsu_rdata, 64'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) return;
        end
        check(tag, 64'(busy) + 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (grants.size() >= n) return;
        end
        check(tag, 64'(grants.size()), 64'(n));
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    bit exp_g[4];

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_addr       = 64'h0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        lsu_addr       = 64'h0;
        lsu_wdata      = 64'h0;
        lsu_wmask      = 8'h00;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'h0;
        do_reset();

        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);

        // Single fetch with exact cycle timing
        cyc();
        ifu_req_valid = 1'b1;
        ifu_addr      = 64'h8000_0000;
        @(negedge clk);
        check("fetch_ready_c0", 64'(ifu_req_ready), 64'd1);
        cyc();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        check("fetch_memvalid_c1", 64'(mem_req_valid), 64'd1);
        check("fetch_noresp_c1", 64'(ifu_resp_valid), 64'd0);
        cyc();
        @(negedge clk);
        check("fetch_resp_c2", 64'(ifu_resp_valid), 64'd1);
        check("fetch_rdata_c2", ifu_rdata, 64'h413);
        cyc();
        @(negedge clk);
        check("fetch_idle_c3", 64'(busy), 64'd0);

        // Store, then a load with a nonzero mask that must be dropped
        cyc();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 64'h8000_1008;
        lsu_wdata     = 64'h1122_3344_5566_7788;
        lsu_wmask     = 8'hff;
        wait_grants(2, "store_grant_timeout");
        cyc();
        lsu_req_valid = 1'b0;
        wait_idle("store_timeout");
        cyc();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 64'h8000_2010;
        lsu_wmask     = 8'h0f;
        wait_grants(3, "load_grant_timeout");
        cyc();
        lsu_req_valid = 1'b0;
        wait_idle("load_timeout");

        // Tie: both held valid, LSU drops after its third grant
        do_reset();
        grants.delete();
        lsu_wen       = 1'b0;
        lsu_addr      = 64'h8000_3000;
        ifu_addr      = 64'h8000_0100;
        lsu_req_valid = 1'b1;
        ifu_req_valid = 1'b1;
        wait_grants(3, "tie_grant3_timeout");
        cyc();
        lsu_req_valid = 1'b0;
        wait_grants(4, "tie_grant4_timeout");
        cyc();
        ifu_req_valid = 1'b0;
        wait_idle("tie_timeout");
`ifdef MEM_ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("tie_order", 64'(grants[i]), 64'(exp_g[i]));
            else check("tie_missing", 64'(grants.size()), 64'd4);
        end

        // Spurious response in IDLE, then backpressure in REQ
        cyc();
        auto_mem       = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hbad0_bad0;
        @(negedge clk);
        check("idle_spur_busy", 64'(busy), 64'd0);
        check("idle_spur_resp", 64'(ifu_resp_valid || lsu_resp_valid), 64'd0);
        cyc();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 64'h8000_0abc;
        @(negedge clk);
        check("bp_ready", 64'(ifu_req_ready), 64'd1);
        cyc();
        ifu_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_resp_valid = (k == 1 || k == 2);
            mem_rdata      = 64'hdead_beef_0000_0000 + 64'(k);
            @(negedge clk);
            check("bp_valid", 64'(mem_req_valid), 64'd1);
            check("bp_addr", mem_addr, 64'h8000_0abc);
            check("bp_wen", 64'(mem_wen), 64'd0);
            check("bp_noresp", 64'(ifu_resp_valid || lsu_resp_valid), 64'd0);
            cyc();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(mem_req_valid), 64'd1);
        cyc();
        @(negedge clk);
        check("bp_resp_wait", 64'(busy), 64'd1);
        check("bp_resp_wait_nv", 64'(ifu_resp_valid), 64'd0);
        cyc();
        mem_resp_valid = 1'b1;
        mem_rdata      = data_of(64'h8000_0abc);
        @(negedge clk);
        check("bp_resp", 64'(ifu_resp_valid), 64'd1);
        cyc();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("bp_done", 64'(busy), 64'd0);

        // Reset while in RESP, then a late memory response
        cyc();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b0;
        lsu_addr      = 64'h8000_4000;
        @(negedge clk);
        check("rr_ready", 64'(lsu_req_ready), 64'd1);
        cyc();
        lsu_req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rr_in_resp", 64'(busy), 64'd1);
        cyc();
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h0bad_cafe;
        @(negedge clk);
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_ifu_resp", 64'(ifu_resp_valid), 64'd0);
        check("rr_lsu_resp", 64'(lsu_resp_valid), 64'd0);
        check("rr_mem_valid", 64'(mem_req_valid), 64'd0);
        check("rr_mem_addr", mem_addr, 64'h0);
        check("rr_mem_wen", 64'(mem_wen), 64'd0);
        check("rr_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rr_lsu_rdata", lsu_rdata, 64'h0);
        cyc();
        mem_resp_valid = 1'b0;
        auto_mem       = 1'b1;
        @(negedge clk);
        check("rr_stays_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
